// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, access sizes, owner ids.
package ram_arbiter_pkg;

    // One-hot arbiter states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_OWN0 = 3'b010,
        ST_OWN1 = 3'b100
    } state_e;

    // Access size codes carried on *_hb.
    localparam logic [1:0] HB_WORD = 2'b10;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_BYTE = 2'b00;

    // Owner identifiers used by the round-robin history bit.
    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    // Number of bytes touched by an access of the given size code.
    function automatic logic [2:0] hb_bytes(input logic [1:0] hb);
        logic [2:0] n;
        n = 3'd1;
        if (hb == HB_WORD) n = 3'd4;
        else if (hb == HB_HALF) n = 3'd2;
        else if (hb == HB_BYTE) n = 3'd1;
        return n;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two master ports and the RAM port seen by the arbiter.
//
// Handshake: a master raises mX_req_i with its fields stable and holds it until
// it sees a one-cycle mX_gnt_o (done, data on mX_rdata_o) or mX_err_o (aborted
// by the watchdog). Dropping req earlier abandons the access silently. Towards
// the RAM, ram_req_o/ram_ce_o stay high with fields stable until ram_gnt_i; the
// RAM presents ram_rdata_i in the ram_gnt_i cycle.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;

    // Instruction-fetch master (read-only).
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o;
    logic        m0_err_o;
    logic [31:0] m0_rdata_o;

    // Load/store master.
    logic        m1_req_i;
    logic        m1_we_i;
    logic [1:0]  m1_hb_i;
    logic        m1_uload_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_err_o;
    logic [31:0] m1_rdata_o;

    // Shared single-port RAM.
    logic        ram_ce_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [1:0]  ram_hb_o;
    logic        ram_uload_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic        ram_gnt_i;
    logic [31:0] ram_rdata_i;

    // Current arbiter state, for observation only.
    state_e      dbg_state_o;

    // Arbiter side.
    modport slave (
        input  m0_req_i, m0_addr_i,
        output m0_gnt_o, m0_err_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_hb_i, m1_uload_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_err_o, m1_rdata_o,
        output ram_ce_o, ram_req_o, ram_we_o, ram_hb_o, ram_uload_o,
        output ram_addr_o, ram_wdata_o,
        input  ram_gnt_i, ram_rdata_i,
        output dbg_state_o
    );

    // Environment side: the two masters and the RAM.
    modport master (
        output m0_req_i, m0_addr_i,
        input  m0_gnt_o, m0_err_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_hb_i, m1_uload_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_err_o, m1_rdata_o,
        input  ram_ce_o, ram_req_o, ram_we_o, ram_hb_o, ram_uload_o,
        input  ram_addr_o, ram_wdata_o,
        output ram_gnt_i, ram_rdata_i,
        input  dbg_state_o
    );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the master that
// did not own the RAM last wins. Output is one-hot or zero.
module rr_pick2
    import ram_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Pick the winner from the request pair and the history bit.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == OWN_M1) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between instruction fetch (m0) and the LSU
// (m1). One owner is locked for a whole RAM handshake, its fields are steered
// to the RAM, and gnt/rdata go back to that owner only. A watchdog aborts an
// owner the RAM never answers so neither master can hang.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CW      = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ram_arbiter_if.slave  bus
);

    // Last owner cycle before the watchdog fires (wdog counts from 0).
    localparam logic [CW-1:0] WDOG_LIM = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic [31:0]   m0_rdata_q, m0_rdata_d;
    logic [31:0]   m1_rdata_q, m1_rdata_d;

    logic [1:0]    pick;
    logic          own_id;
    logic          own_req;
    logic          done_gnt;
    logic          done_err;

    rr_pick2 u_pick (
        .req_i  ({bus.m1_req_i, bus.m0_req_i}),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Which master the current owner state refers to, and its live request.
    assign own_id  = (state_q == ST_OWN1) ? OWN_M1 : OWN_M0;
    assign own_req = (own_id == OWN_M1) ? bus.m1_req_i : bus.m0_req_i;

    // Next state, history bit and watchdog; gnt beats both abort and timeout.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        done_gnt = 1'b0;
        done_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (pick[0]) state_d = ST_OWN0;
                else if (pick[1]) state_d = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (bus.ram_gnt_i) begin
                    done_gnt = 1'b1;
                    last_d   = own_id;
                    wdog_d   = '0;
                    state_d  = ST_IDLE;
                end else if (!own_req) begin
                    // Master gave up: leave quietly, history untouched.
                    wdog_d  = '0;
                    state_d = ST_IDLE;
                end else if (wdog_q == WDOG_LIM) begin
                    // Charge the stalled owner so the other master wins the next tie.
                    done_err = 1'b1;
                    last_d   = own_id;
                    wdog_d   = '0;
                    state_d  = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                wdog_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture RAM read data for the owner on its gnt; otherwise hold.
    always_comb begin
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        if (done_gnt && (own_id == OWN_M0)) m0_rdata_d = bus.ram_rdata_i;
        if (done_gnt && (own_id == OWN_M1)) m1_rdata_d = bus.ram_rdata_i;
    end

    // State, history, watchdog and read-data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            last_q     <= OWN_M1;
            wdog_q     <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wdog_q     <= wdog_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Steer the owner's fields to the RAM; m0 is always a plain word read.
    always_comb begin
        bus.ram_req_o   = 1'b0;
        bus.ram_ce_o    = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_hb_o    = 2'b00;
        bus.ram_uload_o = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        case (state_q)
            ST_OWN0: begin
                bus.ram_req_o  = bus.m0_req_i;
                bus.ram_ce_o   = bus.m0_req_i;
                bus.ram_hb_o   = HB_WORD;
                bus.ram_addr_o = bus.m0_addr_i;
            end
            ST_OWN1: begin
                bus.ram_req_o   = bus.m1_req_i;
                bus.ram_ce_o    = bus.m1_req_i;
                bus.ram_we_o    = bus.m1_we_i;
                bus.ram_hb_o    = bus.m1_hb_i;
                bus.ram_uload_o = bus.m1_uload_i;
                bus.ram_addr_o  = bus.m1_addr_i;
                bus.ram_wdata_o = bus.m1_wdata_i;
            end
            default: ;
        endcase
    end

    // Completion, abort and read data go back to the owner only.
    assign bus.m0_gnt_o    = done_gnt && (own_id == OWN_M0);
    assign bus.m1_gnt_o    = done_gnt && (own_id == OWN_M1);
    assign bus.m0_err_o    = done_err && (own_id == OWN_M0);
    assign bus.m1_err_o    = done_err && (own_id == OWN_M1);
    assign bus.m0_rdata_o  = m0_rdata_d;
    assign bus.m1_rdata_o  = m1_rdata_d;
    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle vector table for single and tied
// transactions, then hand-written sequences for alternation, watchdog, master
// abort and mid-transaction reset. A small RAM model answers 2 cycles after req.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int TIMEOUT = 15;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] D0 = 32'hDEAD_BEEF;
    localparam logic [31:0] A1 = 32'h0000_0040;
    localparam logic [31:0] D1 = 32'h0040_FFBF;
    localparam logic [31:0] A2 = 32'h0000_0021;
    localparam logic [31:0] W2 = 32'h0000_00AB;
    localparam logic [31:0] D2 = 32'h0021_FFDE;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if bus();

    ram_arbiter #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // ---------------- RAM model ----------------
    logic [7:0] ram_cnt = 8'd0;
    logic       ram_stall = 1'b0;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Counts consecutive cycles of ram_req_o; answers on the third.
    always @(posedge clk) ram_cnt <= bus.ram_req_o ? ram_cnt + 8'd1 : 8'd0;
    assign bus.ram_gnt_i   = bus.ram_req_o && (ram_cnt == 8'd2) && !ram_stall;
    assign bus.ram_rdata_i = bus.ram_gnt_i ? ram_word(bus.ram_addr_o) : 32'h0BAD_F00D;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err = 0;
    logic [40:0] exp_q[$];   // {owner, grant cycle[7:0], rdata}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_m0(input logic req, input logic [31:0] addr);
        bus.m0_req_i  = req;
        bus.m0_addr_i = addr;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [1:0] hb,
                            input logic uload, input logic [31:0] addr, input logic [31:0] wdata);
        bus.m1_req_i   = req;
        bus.m1_we_i    = we;
        bus.m1_hb_i    = hb;
        bus.m1_uload_i = uload;
        bus.m1_addr_i  = addr;
        bus.m1_wdata_i = wdata;
    endtask

    task automatic idle_inputs();
        drive_m0(1'b0, 32'h0);
        drive_m1(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Holds reset for a cycle, checks the reset state, releases at a negedge.
    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1;
        check("rst.state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        check("rst.ram_req", 32'(bus.ram_req_o), 32'h0);
        check("rst.m0_rdata", bus.m0_rdata_o, 32'h0);
        check("rst.m1_rdata", bus.m1_rdata_o, 32'h0);
        check("rst.gnt", {30'h0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic        m1_we;
        logic [1:0]  m1_hb;
        logic        m1_uload;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
        logic        e_req;
        logic        e_we;
        logic [1:0]  e_hb;
        logic        e_uload;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_m0_gnt;
        logic [31:0] e_m0_rdata;
        logic        e_m1_gnt;
        logic [31:0] e_m1_rdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vec[NV];

    initial begin : global_timeout
        #100000;
        $display("FAIL global_timeout: run still active at %0t", $time);
        $fatal(1);
    end

    initial begin : main
        logic [40:0] e;
        logic        owner;

        // m0 read at 0x10, then idle (cycles 0..5).
        vec[0]  = '{1, 1, A0, 0, 0, 2'b00, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0,  0, 0};
        vec[1]  = '{0, 1, A0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 2'b10, 0, A0, 0, 0, 0,  0, 0};
        vec[2]  = '{0, 1, A0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 2'b10, 0, A0, 0, 0, 0,  0, 0};
        vec[3]  = '{0, 1, A0, 0, 0, 2'b00, 0, 0, 0,  1, 0, 2'b10, 0, A0, 0, 1, D0, 0, 0};
        vec[4]  = '{0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, D0, 0, 0};
        vec[5]  = '{0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, D0, 0, 0};
        // Tie from reset: m0 first, then m1 byte store (cycles 0..8).
        vec[6]  = '{1, 1, A1, 1, 1, 2'b00, 1, A2, W2, 0, 0, 2'b00, 0, 0, 0,  0, 0,  0, 0};
        vec[7]  = '{0, 1, A1, 1, 1, 2'b00, 1, A2, W2, 1, 0, 2'b10, 0, A1, 0, 0, 0,  0, 0};
        vec[8]  = '{0, 1, A1, 1, 1, 2'b00, 1, A2, W2, 1, 0, 2'b10, 0, A1, 0, 0, 0,  0, 0};
        vec[9]  = '{0, 1, A1, 1, 1, 2'b00, 1, A2, W2, 1, 0, 2'b10, 0, A1, 0, 1, D1, 0, 0};
        vec[10] = '{0, 0, 0,  1, 1, 2'b00, 1, A2, W2, 0, 0, 2'b00, 0, 0, 0,  0, D1, 0, 0};
        vec[11] = '{0, 0, 0,  1, 1, 2'b00, 1, A2, W2, 1, 1, 2'b00, 1, A2, W2, 0, D1, 0, 0};
        vec[12] = '{0, 0, 0,  1, 1, 2'b00, 1, A2, W2, 1, 1, 2'b00, 1, A2, W2, 0, D1, 0, 0};
        vec[13] = '{0, 0, 0,  1, 1, 2'b00, 1, A2, W2, 1, 1, 2'b00, 1, A2, W2, 0, D1, 1, D2};
        vec[14] = '{0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, 0, 2'b00, 0, 0, 0,  0, D1, 0, D2};

        for (int i = 0; i < NV; i++) begin
            if (vec[i].rst) apply_reset();
            else @(negedge clk);
            drive_m0(vec[i].m0_req, vec[i].m0_addr);
            drive_m1(vec[i].m1_req, vec[i].m1_we, vec[i].m1_hb, vec[i].m1_uload,
                     vec[i].m1_addr, vec[i].m1_wdata);
            #1;
            check($sformatf("v%0d.ram_req", i),   32'(bus.ram_req_o),   32'(vec[i].e_req));
            check($sformatf("v%0d.ram_ce", i),    32'(bus.ram_ce_o),    32'(vec[i].e_req));
            check($sformatf("v%0d.ram_we", i),    32'(bus.ram_we_o),    32'(vec[i].e_we));
            check($sformatf("v%0d.ram_hb", i),    32'(bus.ram_hb_o),    32'(vec[i].e_hb));
            check($sformatf("v%0d.ram_uload", i), 32'(bus.ram_uload_o), 32'(vec[i].e_uload));
            check($sformatf("v%0d.ram_addr", i),  bus.ram_addr_o,       vec[i].e_addr);
            check($sformatf("v%0d.ram_wdata", i), bus.ram_wdata_o,      vec[i].e_wdata);
            check($sformatf("v%0d.m0_gnt", i),    32'(bus.m0_gnt_o),    32'(vec[i].e_m0_gnt));
            check($sformatf("v%0d.m0_rdata", i),  bus.m0_rdata_o,       vec[i].e_m0_rdata);
            check($sformatf("v%0d.m1_gnt", i),    32'(bus.m1_gnt_o),    32'(vec[i].e_m1_gnt));
            check($sformatf("v%0d.m1_rdata", i),  bus.m1_rdata_o,       vec[i].e_m1_rdata);
            check($sformatf("v%0d.err", i),       {30'h0, bus.m1_err_o, bus.m0_err_o}, 32'h0);
        end

        // ---- both masters hold requests: grants alternate, 4 cycles apart ----
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            owner = k[0];
            exp_q.push_back({owner, 8'(3 + 4 * k), ram_word(owner ? 32'h200 : 32'h100)});
        end
        drive_m0(1'b1, 32'h100);
        drive_m1(1'b1, 1'b0, HB_WORD, 1'b0, 32'h200, 32'h0);
        for (int c = 0; c < 34; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.m0_gnt_o || bus.m1_gnt_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL alt.extra_gnt: got a grant at cycle %0d, expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    owner = bus.m1_gnt_o;
                    check("alt.both_gnt", 32'(bus.m0_gnt_o & bus.m1_gnt_o), 32'h0);
                    check("alt.owner", 32'(owner), 32'(e[40]));
                    check("alt.cycle", 32'(c), 32'(e[39:32]));
                    check("alt.rdata", owner ? bus.m1_rdata_o : bus.m0_rdata_o, e[31:0]);
                end
            end
        end
        check("alt.remaining", 32'(exp_q.size()), 32'h0);

        // ---- watchdog: m0 read first, then a stalled m1 access ----
        apply_reset();
        drive_m0(1'b1, A0);
        for (int c = 1; c <= 3; c++) @(negedge clk);
        #1;
        check("wd.pre_m0_gnt", 32'(bus.m0_gnt_o), 32'h1);
        @(negedge clk);
        drive_m0(1'b0, 32'h0);
        drive_m1(1'b1, 1'b0, HB_WORD, 1'b0, 32'h33, 32'h0);
        ram_stall = 1'b1;
        #1;
        check("wd.idle", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("wd.err.k%0d", k), 32'(bus.m1_err_o), 32'(k == TIMEOUT));
            check($sformatf("wd.req.k%0d", k), 32'(bus.ram_req_o), 32'h1);
            check($sformatf("wd.gnt.k%0d", k), 32'(bus.m1_gnt_o | bus.m0_err_o), 32'h0);
        end
        @(negedge clk);
        ram_stall = 1'b0;
        drive_m0(1'b1, A0);
        #1;
        check("wd.after_state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        check("wd.after_err", 32'(bus.m1_err_o), 32'h0);
        @(negedge clk);
        #1;
        check("wd.tie_state", 32'(bus.dbg_state_o), 32'(ST_OWN0));
        check("wd.tie_addr", bus.ram_addr_o, A0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("wd.tie_m0_gnt", 32'(bus.m0_gnt_o), 32'h1);
        check("wd.tie_m0_rdata", bus.m0_rdata_o, D0);
        check("wd.tie_m1_gnt", 32'(bus.m1_gnt_o), 32'h0);
        @(negedge clk);
        idle_inputs();

        // ---- m1 abandons its request at owner cycle 2 ----
        apply_reset();
        drive_m1(1'b1, 1'b0, HB_WORD, 1'b0, 32'h30, 32'h0);
        @(negedge clk);
        #1;
        check("ab.c1_req", 32'(bus.ram_req_o), 32'h1);
        check("ab.c1_addr", bus.ram_addr_o, 32'h30);
        @(negedge clk);
        drive_m1(1'b0, 1'b0, HB_WORD, 1'b0, 32'h30, 32'h0);
        #1;
        check("ab.c2_req", 32'(bus.ram_req_o), 32'h0);
        check("ab.c2_ce", 32'(bus.ram_ce_o), 32'h0);
        check("ab.c2_pulses", {30'h0, bus.m1_gnt_o, bus.m1_err_o}, 32'h0);
        @(negedge clk);
        drive_m0(1'b1, A0);
        #1;
        check("ab.c3_state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        check("ab.c3_req", 32'(bus.ram_req_o), 32'h0);
        @(negedge clk);
        #1;
        check("ab.c4_state", 32'(bus.dbg_state_o), 32'(ST_OWN0));
        check("ab.c4_gnt", 32'(bus.m0_gnt_o), 32'h0);
        @(negedge clk);
        #1;
        check("ab.c5_gnt", 32'(bus.m0_gnt_o), 32'h0);
        @(negedge clk);
        #1;
        check("ab.c6_m0_gnt", 32'(bus.m0_gnt_o), 32'h1);
        check("ab.c6_m0_rdata", bus.m0_rdata_o, D0);
        check("ab.c6_m1_gnt", 32'(bus.m1_gnt_o | bus.m1_err_o), 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("ab.c7_state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        check("ab.c7_m0_rdata", bus.m0_rdata_o, D0);

        // ---- reset asserted while m1 owns the RAM ----
        @(negedge clk);
        drive_m1(1'b1, 1'b1, HB_BYTE, 1'b0, 32'h44, 32'h55);
        @(negedge clk);
        #1;
        check("rs.own_we", 32'(bus.ram_we_o), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rs.state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        check("rs.ram_req", 32'(bus.ram_req_o | bus.ram_ce_o | bus.ram_we_o), 32'h0);
        check("rs.ram_addr", bus.ram_addr_o, 32'h0);
        check("rs.ram_wdata", bus.ram_wdata_o, 32'h0);
        check("rs.m0_rdata", bus.m0_rdata_o, 32'h0);
        check("rs.pulses", {28'h0, bus.m0_gnt_o, bus.m0_err_o, bus.m1_gnt_o, bus.m1_err_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        drive_m0(1'b1, A0);
        #1;
        check("rs.c0_req", 32'(bus.ram_req_o), 32'h0);
        @(negedge clk);
        #1;
        check("rs.c1_req", 32'(bus.ram_req_o), 32'h1);
        @(negedge clk);
        #1;
        check("rs.c2_gnt", 32'(bus.m0_gnt_o), 32'h0);
        @(negedge clk);
        #1;
        check("rs.c3_gnt", 32'(bus.m0_gnt_o), 32'h1);
        check("rs.c3_rdata", bus.m0_rdata_o, D0);
        @(negedge clk);
        idle_inputs();
        #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter that shares the single-port data RAM between the instruction-fetch unit (m0, read-only) and the load/store unit (m1, read/write).
- Picks an owner, locks the owner for one full RAM handshake (req to gnt), and steers the owner's fields to the RAM.
- Returns the RAM's gnt and rdata to the owner only.
- Sits between the core's memory ports and the RAM. Includes a watchdog so a stalled RAM cannot hang a master.

Parameters:
- TIMEOUT, 15: max cycles in an owner state without gnt_i before abort; must be ≥4.
- CW, 4: watchdog counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- m0_req_i  in  1  fetch request; held until m0_gnt_o or m0_err_o
- m0_addr_i  in  32  fetch byte address, word-aligned
- m0_gnt_o  out  1  one-cycle completion pulse for m0
- m0_err_o  out  1  one-cycle watchdog abort pulse for m0
- m0_rdata_o  out  32  fetch data
- m1_req_i  in  1  LSU request; held until m1_gnt_o or m1_err_o
- m1_we_i  in  1  write enable
- m1_hb_i  in  2  size: 10 word, 01 half, 00 byte
- m1_uload_i  in  1  unsigned load
- m1_addr_i  in  32  byte address
- m1_wdata_i  in  32  store data
- m1_gnt_o  out  1  completion pulse for m1
- m1_err_o  out  1  watchdog abort pulse for m1
- m1_rdata_o  out  32  load data
- ram_ce_o  out  1  RAM chip enable
- ram_req_o  out  1  RAM request
- ram_we_o  out  1  to RAM
- ram_hb_o  out  2  to RAM
- ram_uload_o  out  1  to RAM
- ram_addr_o  out  32  to RAM
- ram_wdata_o  out  32  to RAM
- ram_gnt_i  in  1  RAM completion
- ram_rdata_i  in  32  RAM read data; valid in the ram_gnt_i cycle

Behaviour:
- Reset (async, rst_ni low):
  - state=IDLE, last_owner=1 (so m0 wins the first tie), wdog=0.
  - m0_rdata_q and m1_rdata_q = 0.
  - All outputs 0.
- States: IDLE, OWN0, OWN1 (one-hot, 3 bits).
- IDLE:
  - ram_req_o=0 and ram_ce_o=0.
  - Only m0 requesting → OWN0. Only m1 requesting → OWN1.
  - Both requesting → grant the master that is not last_owner.
  - Neither requesting → stay in IDLE.
- OWNx:
  - ram_req_o = ram_ce_o = mx_req_i.
  - ram_* fields are muxed combinationally from master x.
  - For m0: we=0, hb=10, uload=0, wdata=0.
  - wdog increments each cycle.
- Handshake:
  - In OWNx, when ram_gnt_i=1: mx_gnt_o=ram_gnt_i in the same cycle, mx_rdata_q<=ram_rdata_i, last_owner<=x, wdog<=0, next state IDLE.
  - The other master's gnt_o is always 0.
- Read data:
  - mx_rdata_o = ram_rdata_i while (OWNx & ram_gnt_i); otherwise mx_rdata_o = mx_rdata_q.
- Latency:
  - Request seen in IDLE at cycle 0 → OWN at cycle 1 → gnt at cycle 3 (RAM takes 2 cycles after req).
  - Minimum of 1 IDLE cycle between transactions. Back-to-back issue rate is 1 transaction per 4 cycles.
- Abort by master (mx_req_i drops in OWNx with no gnt):
  - ram_req_o drops the same cycle.
  - Next state IDLE, wdog<=0, no gnt or err pulse, last_owner unchanged.
- Watchdog:
  - In OWNx, when wdog==TIMEOUT-1 and no gnt: mx_err_o=1 for one cycle.
  - Next state IDLE, wdog<=0, last_owner<=x so the other master gets the next tie.
- Simultaneous events:
  - gnt and the watchdog limit in the same cycle → gnt wins, no err.
  - gnt and req drop in the same cycle → gnt still delivered.
- Requests arriving while another master owns the RAM are ignored until IDLE; no queueing.
- Misalignment is not checked here; the RAM suppresses misaligned accesses. A misaligned access never gnts, so it ends in err via the watchdog.
- Reset mid-transaction: immediate return to IDLE with all pulses low. A RAM still mid-sequence finishes on its own; the arbiter's first IDLE cycle covers the RAM's RSTS→IDLE step.

Decomposition:
- Shared header pygmy_defs.vh holds:
  - state encodings ST_IDLE/ST_OWN0/ST_OWN1
  - HB_WORD/HB_HALF/HB_BYTE size codes
  - owner ids OWN_M0/OWN_M1
- One sub-module, rr_pick2: combinational 2-way round-robin picker with inputs req[1:0] and last, and output a one-hot grant. Arbiter FSM, mux and watchdog stay in ram_arbiter.

Test Plan:
- m0 read at 0x10; RAM model returns 0xDEADBEEF → ram_req_o rises at cycle 1, m0_gnt_o and m0_rdata_o=0xDEADBEEF at cycle 3, m0_rdata_o holds after that, m1 outputs stay 0.
- m0 and m1 request in the same cycle from reset → m0 served first. m1 (we=1, hb=00, addr=0x21, wdata=0xAB) is driven to the RAM at cycle 5 and gets m1_gnt_o at cycle 7.
- Both masters hold requests continuously for 8 transactions → grants alternate m0, m1, m0, ..., each grant 4 cycles apart.
- RAM model never asserts gnt → m1_err_o pulses exactly at the cycle-15 owner cycle (TIMEOUT=15), arbiter returns to IDLE, the next tie goes to m0.
- m1 drops req at owner cycle 2 → ram_req_o drops the same cycle, no gnt or err. A subsequent m0 request completes normally with no spurious gnt.
- rst_ni asserted in OWN1 at owner cycle 2 → all outputs 0 immediately. After release, an m0 request gnts at cycle 3 with correct data.
